// File: rtl/sample_sequencer.sv
// Per-sample scheduler between codec and DSP engine: one-entry pending buffer, overrun counting,
// engine timeout with dry-sample substitution, and bypass routing.
module sample_sequencer #(
  parameter int unsigned DataWidth     = 16,
  parameter int unsigned TimeoutCycles = 2048
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] adc_sample_i,
  input  logic                 adc_valid_i,
  input  logic                 bypass_en_i,
  output logic [DataWidth-1:0] eng_in_sample_o,
  output logic                 eng_sample_ready_o,
  input  logic                 eng_ready_i,
  input  logic [DataWidth-1:0] eng_out_sample_i,
  output logic [DataWidth-1:0] dac_sample_o,
  output logic                 dac_valid_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 timeout_o,
  output logic [15:0]          overrun_count_o,
  input  logic                 clear_flags_i
);

  localparam int unsigned TimerW = $clog2(TimeoutCycles);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StWaitAccept, StWaitDone} state_e;

  state_e                 state_q, state_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [DataWidth-1:0]   pend_data_q, pend_data_d;
  logic [DataWidth-1:0]   eng_in_q, eng_in_d;
  logic                   eng_start_q, eng_start_d;
  logic [DataWidth-1:0]   dac_sample_q, dac_sample_d;
  logic                   dac_valid_q, dac_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            count_q, count_d;

  logic                   start_valid;
  logic [DataWidth-1:0]   start_data;
  logic                   overrun_evt;
  logic                   timeout_evt;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    eng_in_d     = eng_in_q;
    eng_start_d  = 1'b0;
    dac_sample_d = dac_sample_q;
    dac_valid_d  = 1'b0;
    start_valid  = 1'b0;
    start_data   = adc_sample_i;
    overrun_evt  = 1'b0;
    timeout_evt  = 1'b0;

    case (state_q)
      StIdle: begin
        // Pending sample has priority; a simultaneous new sample refills the buffer.
        if (pend_valid_q) begin
          start_valid  = 1'b1;
          start_data   = pend_data_q;
          pend_valid_d = adc_valid_i;
          if (adc_valid_i) pend_data_d = adc_sample_i;
        end else if (adc_valid_i) begin
          start_valid = 1'b1;
        end
        if (start_valid) begin
          if (bypass_en_i) begin
            dac_sample_d = start_data;
            dac_valid_d  = 1'b1;
          end else begin
            eng_in_d    = start_data;
            eng_start_d = 1'b1;
            timer_d     = '0;
            state_d     = StWaitAccept;
          end
        end
      end
      StWaitAccept, StWaitDone: begin
        timer_d = timer_q + TimerW'(1);
        if (state_q == StWaitDone && eng_ready_i) begin
          dac_sample_d = eng_out_sample_i;
          dac_valid_d  = 1'b1;
          state_d      = StIdle;
        end else if (timer_q == TimerLast) begin
          // eng_in_q still holds the dry sample issued to the engine
          dac_sample_d = eng_in_q;
          dac_valid_d  = 1'b1;
          timeout_evt  = 1'b1;
          state_d      = StIdle;
        end else if (state_q == StWaitAccept && !eng_ready_i) begin
          state_d = StWaitDone;
        end
        if (adc_valid_i) begin
          if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_data_d  = adc_sample_i;
          end else begin
            overrun_evt = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);

    // New events override a coincident clear.
    overrun_d = clear_flags_i ? 1'b0 : overrun_q;
    timeout_d = clear_flags_i ? 1'b0 : timeout_q;
    count_d   = clear_flags_i ? 16'd0 : count_q;
    if (overrun_evt) begin
      overrun_d = 1'b1;
      if (clear_flags_i)            count_d = 16'd1;
      else if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
    if (timeout_evt) timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      eng_in_q     <= '0;
      eng_start_q  <= 1'b0;
      dac_sample_q <= '0;
      dac_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      eng_in_q     <= eng_in_d;
      eng_start_q  <= eng_start_d;
      dac_sample_q <= dac_sample_d;
      dac_valid_q  <= dac_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign eng_in_sample_o    = eng_in_q;
  assign eng_sample_ready_o = eng_start_q;
  assign dac_sample_o       = dac_sample_q;
  assign dac_valid_o        = dac_valid_q;
  assign busy_o             = busy_q;
  assign overrun_o          = overrun_q;
  assign timeout_o          = timeout_q;
  assign overrun_count_o    = count_q;

endmodule
